mcalu_iter: RTL and testbench
=============================

Name: mcalu_iter

Overview:
- Multi-cycle ALU instance (mcalu0/mcalu1) downstream of the execute reservation stations.
- Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU op per issue, iterates radix-2^BITS_PER_CYCLE, holds the result, then presents it on the writeback request port.
- Busy or holding-result state is exported as a stall, so the reservation station stops issuing to this unit.

Parameters:
- BITS_PER_CYCLE, 1, quotient/multiplier bits retired per iteration; legal values 1 or 2; ITERS = 32/BITS_PER_CYCLE.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- exers_mcalu_issue  in  1  issue strobe from reservation station.
- exers_mcalu_op  in  5  op; bits[2:0]: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU; bits[4:3] ignored.
- exers_robid  in  7  ROB id of issued op.
- exers_rd  in  6  destination tag; bit5 = no register write.
- exers_op1  in  32  rs1 value / dividend.
- exers_op2  in  32  rs2 value / divisor.
- mcalu_stall  out  1  high when an issue would not be accepted.
- mcalu_valid  out  1  writeback request.
- mcalu_robid  out  7  ROB id of result.
- mcalu_rd  out  6  destination tag of result.
- mcalu_result  out  32  result.
- wb_mcalu_stall  in  1  writeback arbiter back-pressure; result is consumed on a cycle with mcalu_valid & ~wb_mcalu_stall.
- rob_flush  in  1  synchronous pipeline flush.

Behaviour:
- Reset (rst=0, async): state IDLE; mcalu_valid=0, mcalu_stall=0, mcalu_robid=0, mcalu_rd=0, mcalu_result=0, iteration counter=0.
- States are IDLE, BUSY, DONE.
- mcalu_stall = (state != IDLE). The unit never accepts in the same cycle as it retires a result; no bypass.
- IDLE: on exers_mcalu_issue & ~rob_flush, latch robid, rd, op, sign flags and operand magnitudes.
  - Normal op: go to BUSY with count=0.
  - Divide by zero or signed overflow (DIV/REM with op1=0x80000000, op2=0xFFFFFFFF): go directly to DONE with the special result. mcalu_valid is high the cycle after acceptance.
- BUSY: one iteration per cycle; count increments. After ITERS iterations (count==ITERS-1 at the edge), apply sign correction and go to DONE.
  - mcalu_valid first asserts ITERS+1 cycles after the acceptance edge: 33 for BITS_PER_CYCLE=1, 17 for 2.
- DONE: mcalu_valid=1; outputs stable while wb_mcalu_stall=1. On ~wb_mcalu_stall, go to IDLE; mcalu_valid drops next cycle.
- Multiply: 64-bit product of magnitudes, negated if the sign flags differ.
  - Operand signed-ness: MUL/MULH treat op1 and op2 as signed; MULHSU treats op1 as signed and op2 as unsigned; MULHU treats both as unsigned.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide: restoring division on magnitudes (signed ops) or raw values (unsigned).
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - Divide by zero: quotient 0xFFFFFFFF; remainder = op1.
  - Overflow: quotient 0x80000000; remainder 0.
- rob_flush (synchronous, highest priority after reset): next state IDLE and mcalu_valid=0 regardless of state. An issue in the same cycle as a flush is dropped.
- Issue while stalled is ignored. The reservation station must not issue then; a bench assertion flags it.
- mcalu_rd[5]=1 ops are computed and written back normally; filtering happens downstream.

Test Plan:
- MULHU, BITS_PER_CYCLE=1: op1=0xFFFFFFFF, op2=0xFFFFFFFF, robid=5 -> mcalu_valid exactly 33 cycles after accept, result=0xFFFFFFFE, robid=5; mcalu_stall high throughout.
- Signed ops: DIV op1=-7 (0xFFFFFFF9), op2=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; MUL op1=-3, op2=4 -> 0xFFFFFFF4; MULHSU op1=-1, op2=2 -> 0xFFFFFFFF.
- Special cases: DIVU op2=0 -> 0xFFFFFFFF; REM op1=0x12345678, op2=0 -> 0x12345678; DIV 0x80000000/0xFFFFFFFF -> 0x80000000. Each valid 1 cycle after accept.
- Back-pressure: hold wb_mcalu_stall=1 for 10 cycles in DONE -> outputs unchanged, mcalu_stall=1. Release -> one consume cycle, then IDLE and mcalu_stall=0 the next cycle; a back-to-back issue is accepted.
- Flush: assert rob_flush mid-BUSY (count=10), and separately in DONE, and coincident with issue -> no mcalu_valid ever produced; mcalu_stall=0 next cycle.
- Reset: drive rst low asynchronously mid-BUSY (no clock edge) -> outputs zero immediately; after release, a DIVU 100/7 returns 14. Repeat with BITS_PER_CYCLE=2 and confirm 17-cycle latency.

Source files
------------

// File: rtl/mcalu_iter.sv
// Iterative multi-cycle ALU: radix-2^BITS_PER_CYCLE shift-add multiply and restoring
// divide on operand magnitudes, result held until the writeback port takes it.
module mcalu_iter #(
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exers_mcalu_issue,
   input  logic [4:0]  exers_mcalu_op,
   input  logic [6:0]  exers_robid,
   input  logic [5:0]  exers_rd,
   input  logic [31:0] exers_op1,
   input  logic [31:0] exers_op2,
   output logic        mcalu_stall,
   output logic        mcalu_valid,
   output logic [6:0]  mcalu_robid,
   output logic [5:0]  mcalu_rd,
   output logic [31:0] mcalu_result,
   input  logic        wb_mcalu_stall,
   input  logic        rob_flush
);

   localparam int unsigned ITERS = 32 / BITS_PER_CYCLE;
   localparam logic [4:0]  LAST  = 5'(ITERS - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e      state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic [2:0]  op_q, op_d;
   logic        neg_q, neg_d;
   logic        neg_rem_q, neg_rem_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] b_q, b_d;
   logic [6:0]  robid_q, robid_d;
   logic [5:0]  rd_q, rd_d;
   logic [31:0] result_q, result_d;

   logic        is_div, sgn1, sgn2, neg1, neg2, div_zero, div_ovf, accept;
   logic [31:0] mag1, mag2, special_res, final_res;
   logic [63:0] step, prod;
   logic [32:0] sum_w, rem_w;
   logic [31:0] lo_w;
   logic        unused_op;

   assign unused_op = ^exers_mcalu_op[4:3];

   // Signed-ness per op: DIV/REM and MUL/MULH fully signed, MULHSU signs op1 only.
   assign is_div      = exers_mcalu_op[2];
   assign sgn1        = is_div ? ~exers_mcalu_op[0] : (exers_mcalu_op[1:0] != 2'b11);
   assign sgn2        = is_div ? ~exers_mcalu_op[0] : ~exers_mcalu_op[1];
   assign neg1        = sgn1 & exers_op1[31];
   assign neg2        = sgn2 & exers_op2[31];
   assign mag1        = neg1 ? -exers_op1 : exers_op1;
   assign mag2        = neg2 ? -exers_op2 : exers_op2;
   assign div_zero    = is_div & (exers_op2 == 32'd0);
   assign div_ovf     = is_div & ~exers_mcalu_op[0] & (exers_op1 == 32'h8000_0000) &
                        (exers_op2 == 32'hFFFF_FFFF);
   assign special_res = exers_mcalu_op[1] ? (div_zero ? exers_op1 : 32'd0)
                                          : (div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);
   assign accept      = (state_q == IDLE) & exers_mcalu_issue & ~rob_flush;

   // acc holds {partial product | multiplier} or {remainder | dividend->quotient}.
   always_comb begin
      step  = acc_q;
      sum_w = '0;
      rem_w = '0;
      lo_w  = '0;
      for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
         if (op_q[2]) begin
            rem_w = step[63:31];
            lo_w  = {step[30:0], 1'b0};
            if (rem_w >= {1'b0, b_q}) begin
               rem_w   = rem_w - {1'b0, b_q};
               lo_w[0] = 1'b1;
            end
            step = {rem_w[31:0], lo_w};
         end else begin
            sum_w = {1'b0, step[63:32]} + (step[0] ? {1'b0, b_q} : 33'd0);
            step  = {sum_w, step[31:1]};
         end
      end
   end

   always_comb begin
      prod      = neg_q ? -step : step;
      final_res = prod[31:0];
      case (op_q)
         3'b000:                 final_res = prod[31:0];
         3'b001, 3'b010, 3'b011: final_res = prod[63:32];
         3'b100, 3'b101:         final_res = neg_q ? -step[31:0] : step[31:0];
         default:                final_res = neg_rem_q ? -step[63:32] : step[63:32];
      endcase
   end

   always_comb begin
      // NOTE: every next-state signal defaults to its held value first so that
      // no branch of this block can leave one unassigned and infer a latch.
      state_d   = state_q;
      count_d   = count_q;
      op_d      = op_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      acc_d     = acc_q;
      b_d       = b_q;
      robid_d   = robid_q;
      rd_d      = rd_q;
      result_d  = result_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               op_d      = exers_mcalu_op[2:0];
               neg_d     = neg1 ^ neg2;
               neg_rem_d = neg1;
               acc_d     = {32'd0, mag1};
               b_d       = mag2;
               count_d   = '0;
               robid_d   = exers_robid;
               rd_d      = exers_rd;
               if (div_zero || div_ovf) begin
                  result_d = special_res;
                  state_d  = DONE;
               end else begin
                  state_d  = BUSY;
               end
            end
         end
         BUSY: begin
            acc_d   = step;
            count_d = count_q + 5'd1;
            if (count_q == LAST) begin
               result_d = final_res;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (!wb_mcalu_stall) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (rob_flush) state_d = IDLE;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         op_q      <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         acc_q     <= '0;
         b_q       <= '0;
         robid_q   <= '0;
         rd_q      <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         op_q      <= op_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         acc_q     <= acc_d;
         b_q       <= b_d;
         robid_q   <= robid_d;
         rd_q      <= rd_d;
         result_q  <= result_d;
      end
   end

   // A flush kills the writeback request in the cycle it arrives.
   assign mcalu_stall  = (state_q != IDLE);
   assign mcalu_valid  = (state_q == DONE) & ~rob_flush;
   assign mcalu_robid  = robid_q;
   assign mcalu_rd     = rd_q;
   assign mcalu_result = result_q;

endmodule

// File: tb/tb_mcalu_iter.sv
// Bench for mcalu_iter: one instance per legal BITS_PER_CYCLE sharing the same
// stimulus, results compared against a plain-arithmetic RISC-V M-extension model.
module tb_mcalu_iter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        exers_mcalu_issue = 1'b0;
   logic [4:0]  exers_mcalu_op = '0;
   logic [6:0]  exers_robid = '0;
   logic [5:0]  exers_rd = '0;
   logic [31:0] exers_op1 = '0;
   logic [31:0] exers_op2 = '0;
   logic        wb_mcalu_stall = 1'b0;
   logic        rob_flush = 1'b0;

   logic        stall1, valid1, stall2, valid2;
   logic [6:0]  robid1, robid2;
   logic [5:0]  rd1, rd2;
   logic [31:0] result1, result2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mcalu_iter #(.BITS_PER_CYCLE(1)) dut1 (
      .clk(clk), .rst(rst), .exers_mcalu_issue(exers_mcalu_issue),
      .exers_mcalu_op(exers_mcalu_op), .exers_robid(exers_robid), .exers_rd(exers_rd),
      .exers_op1(exers_op1), .exers_op2(exers_op2), .mcalu_stall(stall1),
      .mcalu_valid(valid1), .mcalu_robid(robid1), .mcalu_rd(rd1), .mcalu_result(result1),
      .wb_mcalu_stall(wb_mcalu_stall), .rob_flush(rob_flush));

   mcalu_iter #(.BITS_PER_CYCLE(2)) dut2 (
      .clk(clk), .rst(rst), .exers_mcalu_issue(exers_mcalu_issue),
      .exers_mcalu_op(exers_mcalu_op), .exers_robid(exers_robid), .exers_rd(exers_rd),
      .exers_op1(exers_op1), .exers_op2(exers_op2), .mcalu_stall(stall2),
      .mcalu_valid(valid2), .mcalu_robid(robid2), .mcalu_rd(rd2), .mcalu_result(result2),
      .wb_mcalu_stall(wb_mcalu_stall), .rob_flush(rob_flush));

   // The reservation station must never issue into a stalled unit.
   always @(posedge clk)
      if (rst && exers_mcalu_issue && (stall1 || stall2)) begin
         errors++;
         $display("FAIL issue_while_stalled t=%0t stall1=%b stall2=%b", $time, stall1, stall2);
      end

   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      int          ia, ib;
      longint      sa, sb;
      logic [63:0] p;
      ia = int'(a);
      ib = int'(b);
      sa = ia;
      sb = ib;
      p  = '0;
      case (op)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(b); return p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(ia / ib);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(ia % ib);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Issues at the current negedge with wb_mcalu_stall low, checks latency and
   // result on both instances, then checks they are idle one cycle after retiring.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [6:0] robid, input logic [5:0] rd, input string name);
      logic [31:0] exp;
      int          lat1, lat2;
      bit          special, got1, got2, stall_ok1, stall_ok2;
      exp       = model(op, a, b);
      special   = op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      lat1      = special ? 1 : 33;
      lat2      = special ? 1 : 17;
      got1      = 0;
      got2      = 0;
      stall_ok1 = 1;
      stall_ok2 = 1;
      exers_mcalu_issue = 1'b1;
      exers_mcalu_op    = {2'($urandom), op};
      exers_robid       = robid;
      exers_rd          = rd;
      exers_op1         = a;
      exers_op2         = b;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         exers_mcalu_issue = 1'b0;
         if (!got1) begin
            if (valid1) begin
               got1 = 1;
               checks++;
               if (cyc != lat1 || result1 !== exp || robid1 !== robid || rd1 !== rd || !stall1) begin
                  errors++;
                  $display("FAIL %s bpc1 op=%0d a=%h b=%h: cycle %0d result %h robid %h rd %h, expected cycle %0d result %h robid %h rd %h",
                           name, op, a, b, cyc, result1, robid1, rd1, lat1, exp, robid, rd);
               end
            end else if (!stall1) stall_ok1 = 0;
         end
         if (!got2) begin
            if (valid2) begin
               got2 = 1;
               checks++;
               if (cyc != lat2 || result2 !== exp || robid2 !== robid || rd2 !== rd || !stall2) begin
                  errors++;
                  $display("FAIL %s bpc2 op=%0d a=%h b=%h: cycle %0d result %h robid %h rd %h, expected cycle %0d result %h robid %h rd %h",
                           name, op, a, b, cyc, result2, robid2, rd2, lat2, exp, robid, rd);
               end
            end else if (!stall2) stall_ok2 = 0;
         end
         if (got1 && got2) break;
      end
      checks++;
      if (!got1 || !got2 || !stall_ok1 || !stall_ok2) begin
         errors++;
         $display("FAIL %s progress: got valid %b/%b stall held %b/%b, expected 1/1 1/1",
                  name, got1, got2, stall_ok1, stall_ok2);
      end
      @(negedge clk);
      checks++;
      if (valid1 || stall1 || valid2 || stall2) begin
         errors++;
         $display("FAIL %s retire: valid %b/%b stall %b/%b, expected all 0",
                  name, valid1, valid2, stall1, stall2);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({stall1, valid1, robid1, rd1, result1} !== '0 ||
          {stall2, valid2, robid2, rd2, result2} !== '0) begin
         errors++;
         $display("FAIL reset_state: bpc1 %b %b %h %h %h bpc2 %b %b %h %h %h, expected zeros",
                  stall1, valid1, robid1, rd1, result1, stall2, valid2, robid2, rd2, result2);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd5, 6'h03, "mulhu_max");
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 7'd6, 6'h04, "div_neg");
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 7'd7, 6'h05, "rem_neg");
      run_op(3'd0, 32'hFFFF_FFFD, 32'd4, 7'd8, 6'h26, "mul_neg");
      run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 7'd9, 6'h07, "mulhsu_neg");
   endtask

   task automatic test_special();
      run_op(3'd5, 32'hDEAD_BEEF, 32'd0, 7'd10, 6'h08, "divu_zero");
      run_op(3'd6, 32'h1234_5678, 32'd0, 7'd11, 6'h09, "rem_zero");
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 7'd12, 6'h0A, "div_ovf");
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 7'd13, 6'h0B, "rem_ovf");
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a, b;
      for (int n = 0; n < 24; n++) begin
         op = 3'($urandom);
         a  = pick();
         b  = pick();
         run_op(op, a, b, 7'($urandom), 6'($urandom), $sformatf("random%0d", n));
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, exp;
      bit          stable;
      a   = $urandom;
      b   = $urandom;
      exp = model(3'd1, a, b);
      wb_mcalu_stall    = 1'b1;
      exers_mcalu_issue = 1'b1;
      exers_mcalu_op    = 5'b00001;
      exers_robid       = 7'h2A;
      exers_rd          = 6'h21;
      exers_op1         = a;
      exers_op2         = b;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         exers_mcalu_issue = 1'b0;
         if (valid1) break;
      end
      checks++;
      if (!valid1 || !valid2 || result1 !== exp || result2 !== exp) begin
         errors++;
         $display("FAIL hold_result: valid %b/%b result %h/%h, expected 1/1 %h",
                  valid1, valid2, result1, result2, exp);
      end
      stable = 1;
      repeat (10) begin
         @(negedge clk);
         if (!(valid1 && stall1 && result1 === exp && robid1 === 7'h2A && rd1 === 6'h21 &&
               valid2 && stall2 && result2 === exp && robid2 === 7'h2A && rd2 === 6'h21))
            stable = 0;
      end
      checks++;
      if (!stable) begin
         errors++;
         $display("FAIL hold_stable: outputs moved under back-pressure, now %h/%h expected %h",
                  result1, result2, exp);
      end
      wb_mcalu_stall = 1'b0;
      @(negedge clk);
      checks++;
      if (stall1 || valid1 || stall2 || valid2) begin
         errors++;
         $display("FAIL consume: stall %b/%b valid %b/%b, expected 0",
                  stall1, stall2, valid1, valid2);
      end
      run_op(3'd5, 32'd100, 32'd7, 7'h11, 6'h05, "back_to_back");
   endtask

   task automatic test_flush();
      bit seen;
      // Flush while iterating: count is 10 on the 11th cycle after acceptance.
      exers_mcalu_issue = 1'b1;
      exers_mcalu_op    = 5'b00011;
      exers_op1         = $urandom;
      exers_op2         = $urandom;
      repeat (11) begin
         @(negedge clk);
         exers_mcalu_issue = 1'b0;
      end
      rob_flush = 1'b1;
      checks++;
      if (valid1 || valid2 || !stall1 || !stall2) begin
         errors++;
         $display("FAIL flush_busy_pre: valid %b/%b stall %b/%b, expected 0/0 1/1",
                  valid1, valid2, stall1, stall2);
      end
      @(negedge clk);
      rob_flush = 1'b0;
      seen = stall1 || stall2;
      repeat (40) begin
         @(negedge clk);
         if (valid1 || valid2) seen = 1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL flush_busy: stall or valid after flush, expected neither");
      end
      // Flush while holding a result under back-pressure.
      wb_mcalu_stall    = 1'b1;
      exers_mcalu_issue = 1'b1;
      exers_mcalu_op    = 5'b00101;
      exers_op2         = 32'd0;
      @(negedge clk);
      exers_mcalu_issue = 1'b0;
      @(negedge clk);
      rob_flush = 1'b1;
      #1;
      checks++;
      if (valid1 || valid2) begin
         errors++;
         $display("FAIL flush_done_cycle: valid %b/%b during flush, expected 0", valid1, valid2);
      end
      @(negedge clk);
      rob_flush      = 1'b0;
      wb_mcalu_stall = 1'b0;
      seen = stall1 || stall2;
      repeat (40) begin
         @(negedge clk);
         if (valid1 || valid2) seen = 1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL flush_done: stall or valid after flush, expected neither");
      end
      // Issue coinciding with a flush is dropped.
      exers_mcalu_issue = 1'b1;
      exers_mcalu_op    = 5'b00100;
      exers_op2         = 32'd0;
      rob_flush         = 1'b1;
      @(negedge clk);
      exers_mcalu_issue = 1'b0;
      rob_flush         = 1'b0;
      seen = stall1 || stall2;
      repeat (40) begin
         @(negedge clk);
         if (valid1 || valid2 || stall1 || stall2) seen = 1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL flush_issue: issue accepted during flush, expected drop");
      end
   endtask

   task automatic test_async_reset();
      exers_mcalu_issue = 1'b1;
      exers_mcalu_op    = 5'b00000;
      exers_robid       = 7'h55;
      exers_rd          = 6'h15;
      exers_op1         = $urandom;
      exers_op2         = $urandom;
      repeat (6) begin
         @(negedge clk);
         exers_mcalu_issue = 1'b0;
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({stall1, valid1, robid1, rd1, result1} !== '0 ||
          {stall2, valid2, robid2, rd2, result2} !== '0) begin
         errors++;
         $display("FAIL async_reset: bpc1 %b %b %h %h %h bpc2 %b %b %h %h %h, expected zeros",
                  stall1, valid1, robid1, rd1, result1, stall2, valid2, robid2, rd2, result2);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_op(3'd5, 32'd100, 32'd7, 7'h3C, 6'h2E, "post_reset_divu");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_special();
      test_random();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
